// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, default oversample ratio and parity helper.
// The PARITY state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } txState_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic evenParity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_en.sv
// UART transmitter paced by an external oversample tick (en); 8N1 frames, back-to-back capable.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_en
    import uart_pkg::*;
#(
    parameter int Oversample = UART_DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       done
);

    localparam int CntW = $clog2(Oversample);
    localparam logic [CntW-1:0] CntLoad = CntW'(Oversample - 1);

    txState_t        state;
    logic [CntW-1:0] sampleCount;
    logic [2:0]      bitCount;
    logic [7:0]      shiftReg;
`ifdef UART_TX_PARITY_EN
    logic            parityBit;
`endif

    logic bitEnd;
    logic accept;

    // Ready in STOP only on the cycle that completes it, so a new byte
    // accepted there always coincides with the done pulse.
    assign bitEnd = en && (sampleCount == '0);
    assign ready  = (state == TX_IDLE) || ((state == TX_STOP) && bitEnd);
    assign accept = valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TX_IDLE;
            out         <= 1'b1;
            done        <= 1'b0;
            sampleCount <= CntLoad;
            bitCount    <= 3'd0;
            shiftReg    <= 8'd0;
`ifdef UART_TX_PARITY_EN
            parityBit   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                state       <= TX_START;
                out         <= 1'b0;
                shiftReg    <= data;
                sampleCount <= CntLoad;
                bitCount    <= 3'd0;
                done        <= (state == TX_STOP);
`ifdef UART_TX_PARITY_EN
                parityBit   <= evenParity(data);
`endif
            end else if (en && (state != TX_IDLE)) begin
                if (sampleCount != '0) begin
                    sampleCount <= sampleCount - 1'b1;
                end else begin
                    sampleCount <= CntLoad;
                    case (state)
                        TX_START: begin
                            state    <= TX_DATA;
                            out      <= shiftReg[0];
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            bitCount <= 3'd0;
                        end
                        TX_DATA: begin
                            if (bitCount == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state <= TX_PARITY;
                                out   <= parityBit;
`else
                                state <= TX_STOP;
                                out   <= 1'b1;
`endif
                            end else begin
                                out      <= shiftReg[0];
                                shiftReg <= {1'b0, shiftReg[7:1]};
                                bitCount <= bitCount + 3'd1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        TX_PARITY: begin
                            state <= TX_STOP;
                            out   <= 1'b1;
                        end
`endif
                        TX_STOP: begin
                            state <= TX_IDLE;
                            out   <= 1'b1;
                            done  <= 1'b1;
                        end
                        default: begin
                            state <= TX_IDLE;
                            out   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_en.sv
// Table-driven bench for uart_tx_en: per-cycle line waveform, ready and done checks per frame,
// plus hand-written reset sequences. Honours UART_TX_PARITY_EN for frame length and parity bit.
module tb_uart_tx_en;

    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic P0 = 1'b0;
`else
    localparam int NB = 10;
    localparam logic P0 = 1'b1;
`endif
    localparam logic P1 = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       done;

    int checks = 0;
    int errors = 0;

    uart_tx_en #(.Oversample(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Waveform bit 0 = start, bits 8:1 = data LSB first, bit 9 = parity (or stop), bit 10 = stop (or idle).
    typedef struct {
        string      name;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nFrames;
        int         enDiv;
        logic [10:0] w0;
        logic [10:0] w1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #2 after a rising edge; drives one or two frames and checks every cycle.
    task automatic runFrames(input vec_t v);
        int L, frameLen, total, f, r;
        int badOut, badReady, badDone, doneCnt, firstBad;
        logic [10:0] w;
        logic expOut, expReady, expDone;
        L = OS * v.enDiv;
        frameLen = NB * L;
        total = frameLen * v.nFrames;
        badOut = 0; badReady = 0; badDone = 0; doneCnt = 0; firstBad = -1;
        data = v.d0;
        valid = 1'b1;
        en = 1'b1;
        for (int k = 0; k <= total + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) data = v.d1;
            if (k == 0 && v.nFrames == 1) valid = 1'b0;
            if (k == frameLen && v.nFrames == 2) valid = 1'b0;
            en = (((k + 1) % v.enDiv) == 0);
            #1;
            f = k / frameLen;
            r = k % frameLen;
            w = (f == 0) ? v.w0 : v.w1;
            expOut = (k >= total) ? 1'b1 : w[r / L];
            expReady = (k >= total) || (r == frameLen - 1);
            expDone = (k > 0) && (r == 0) && (k <= total);
            if (out !== expOut) begin
                badOut++;
                if (firstBad < 0) firstBad = k;
            end
            if (ready !== expReady) badReady++;
            if (done !== expDone) badDone++;
            if (done === 1'b1) doneCnt++;
        end
        check($sformatf("%s out bad cycles (first at %0d)", v.name, firstBad), badOut, 0);
        check($sformatf("%s ready bad cycles", v.name), badReady, 0);
        check($sformatf("%s done bad cycles", v.name), badDone, 0);
        check($sformatf("%s done count", v.name), doneCnt, v.nFrames);
    endtask

    initial begin
        int dc, bo;
        vecs[0] = '{"f55",      8'h55, 8'h55, 1, 1, {1'b1, P0, 8'h55, 1'b0}, 11'h7FF};
        vecs[1] = '{"fA5",      8'hA5, 8'hA5, 1, 1, {1'b1, P0, 8'hA5, 1'b0}, 11'h7FF};
        vecs[2] = '{"f3C_en4",  8'h3C, 8'h3C, 1, 4, {1'b1, P0, 8'h3C, 1'b0}, 11'h7FF};
        vecs[3] = '{"f12_hold", 8'h12, 8'hFF, 1, 1, {1'b1, P0, 8'h12, 1'b0}, 11'h7FF};
        vecs[4] = '{"b2b00FF",  8'h00, 8'hFF, 2, 1, {1'b1, P0, 8'h00, 1'b0}, {1'b1, P0, 8'hFF, 1'b0}};
        vecs[5] = '{"f07",      8'h07, 8'h07, 1, 1, {1'b1, P1, 8'h07, 1'b0}, 11'h7FF};
        vecs[6] = '{"f03",      8'h03, 8'h03, 1, 1, {1'b1, P0, 8'h03, 1'b0}, 11'h7FF};

        // Reset with valid high: reset must win, line idles high.
        reset = 1'b1;
        valid = 1'b1;
        data = 8'hFF;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out", int'(out), 1);
        check("reset done", int'(done), 0);
        reset = 1'b0;
        valid = 1'b0;
        #1;
        check("reset ready", int'(ready), 1);

        // Abort a frame during data bit 3 (cycles 64..79 after acceptance).
        data = 8'hA5;
        valid = 1'b1;
        en = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) valid = 1'b0;
        end
        check("pre-abort out (bit3 of A5)", int'(out), 0);
        reset = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        #1;
        check("abort out", int'(out), 1);
        check("abort ready", int'(ready), 1);
        check("abort done", int'(done), 0);
        dc = 0;
        bo = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (done === 1'b1) dc++;
            if (out !== 1'b1) bo++;
        end
        check("abort no done", dc, 0);
        check("abort line idle", bo, 0);

        for (int i = 0; i < 7; i++) runFrames(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_en.md
UART_TX_EN -- requirements
Module: uart_tx_en

Interface
REQ-001 SHALL have parameter Oversample, default 16: en pulses per bit period; integer >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  oversample tick; bit timing advances only on cycles with en=1.
REQ-005 SHALL have port data  input  8  byte to send; sampled on acceptance.
REQ-006 SHALL have port valid  input  1  request to send data.
REQ-007 SHALL have port ready  output  1  high when a byte can be accepted.
REQ-008 SHALL have port out  output  1  serial line; idle high.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-011 SHALL assert ready only in IDLE, and in STOP on the final en-cycle (sampleCount==0).
REQ-012 SHALL accept a byte on any clk edge with valid&&ready, independent of en; data latched into shift register that cycle.
REQ-013 SHALL enter START on the edge after acceptance; out registered, low from that cycle.
REQ-014 SHALL load sampleCount with Oversample-1 on every state or bit entry; decrement on en; at en&&sampleCount==0 advance to next bit or state.
REQ-015 SHALL hold each bit (start, data, parity, stop) for exactly Oversample en pulses.
REQ-016 SHALL send data LSB first, 8 bits; bit counter 3 bits; DATA exits after bit 7.
REQ-017 SHALL drive out high in STOP and IDLE.
REQ-018 SHALL pulse done for one cycle on the edge where STOP completes (en&&sampleCount==0).
REQ-019 SHALL, if valid is high at STOP completion, accept the new byte and go STOP->START without an idle bit (back-to-back frames).
REQ-020 SHALL ignore data/valid changes while not ready; latched byte is unaffected.
REQ-021 SHALL freeze all counters and state while en=0; out holds its value.
REQ-022 SHALL sampleCount width $clog2(Oversample); no wrap beyond Oversample-1.

Reset
REQ-023 SHALL on reset: state=IDLE, out=1, ready=1, done=0, sampleCount=Oversample-1, bit counter=0, shift register=0.
REQ-024 SHALL, on reset asserted mid-frame, abort the frame; out=1 on the following edge; no done pulse for the aborted frame.
REQ-025 SHALL give reset priority over valid and en.

Configuration
REQ-026 SHALL, with UART_TX_PARITY_EN defined, insert PARITY between DATA and STOP carrying even parity (XOR of the 8 data bits), Oversample en pulses long.
REQ-027 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic entirely; DATA goes directly to STOP.

Structure
REQ-028 SHALL place the tx state enum and the default oversample constant in shared package uart_pkg, also usable by receive-side logic.
REQ-029 SHALL be a single module with counters inline; no sub-module.

Verification (Oversample=16, en tied high unless stated)
REQ-030 SHALL check: valid with data=0xA5 in IDLE -> out low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, high 16, done pulse at cycle 160 after acceptance, ready high after.
REQ-031 SHALL check: valid held high with 0x00 then 0xFF -> second start bit immediately follows first stop bit; two done pulses 160 cycles apart.
REQ-032 SHALL check: en pulsing 1-in-4 with data=0x3C -> each bit lasts 64 clk cycles; frame 640 cycles.
REQ-033 SHALL check: reset asserted during data bit 3 -> out=1 and ready=1 next cycle, no done; next frame 0x55 correct.
REQ-034 SHALL check: data changed from 0x12 to 0xFF while busy -> transmitted byte remains 0x12.
REQ-035 SHALL check with UART_TX_PARITY_EN: data=0x07 -> parity bit 1 after bit 7; frame 176 cycles; data=0x03 -> parity 0.
